// File: rtl/mux_bus_if.sv
// Multiplexed address/data bus between the core (master) and the memory (slave).
// Ports: req/rw/blen/bus_in/wvalid from master; bus_out/bus_oe/rvalid/wack/busy/err from slave.
interface mux_bus_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int BL_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
);
    logic              req;
    logic              rw;
    logic [BL_W-1:0]   blen;
    logic [DATA_W-1:0] bus_in;
    logic              wvalid;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              rvalid;
    logic              wack;
    logic              busy;
    logic              err;

    modport master (
        output req, rw, blen, bus_in, wvalid,
        input  bus_out, bus_oe, rvalid, wack, busy, err
    );

    modport slave (
        input  req, rw, blen, bus_in, wvalid,
        output bus_out, bus_oe, rvalid, wack, busy, err
    );
endinterface

// File: rtl/mux_bus_memory.sv
// Synchronous memory slave on a multiplexed address/data bus with wrapping bursts.
// Ports: CLK, RST (sync, active-high), bus (mux_bus_if.slave).
module mux_bus_memory #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int BL_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input logic     CLK,
    input logic     RST,
    mux_bus_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [AW-1:0]   PTR_ONE = 1;
    localparam logic [BL_W-1:0] CNT_ONE = 1;
    localparam logic [BL_W-1:0] CNT_ZERO = '0;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [BL_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              rvalid_q, rvalid_d;
    logic              oe_q, oe_d;
    logic              wack_q, wack_d;
    logic              err_q, err_d;
    logic              beat_we;
    logic              mem_we;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        bus_out_d = bus_out_q;
        rvalid_d  = 1'b0;
        oe_d      = 1'b0;
        wack_d    = 1'b0;
        err_d     = 1'b0;
        beat_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    // Upper address bits beyond AW are ignored.
                    ptr_d   = bus.bus_in[AW-1:0];
                    cnt_d   = bus.blen;
                    state_d = bus.rw ? S_RD : S_WR;
                end
            end
            S_RD: begin
                err_d     = bus.req;
                bus_out_d = mem[ptr_q];
                rvalid_d  = 1'b1;
                oe_d      = 1'b1;
                ptr_d     = ptr_q + PTR_ONE;
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WR: begin
                err_d = bus.req;
                if (bus.wvalid) begin
                    beat_we = 1'b1;
                    wack_d  = 1'b1;
                    ptr_d   = ptr_q + PTR_ONE;
                    if (cnt_q == CNT_ZERO) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset wins over a write beat presented in the same cycle.
    assign mem_we = beat_we && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            bus_out_q <= '0;
            rvalid_q  <= 1'b0;
            oe_q      <= 1'b0;
            wack_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            bus_out_q <= bus_out_d;
            rvalid_q  <= rvalid_d;
            oe_q      <= oe_d;
            wack_q    <= wack_d;
            err_q     <= err_d;
        end
    end

    // Storage is not reset so contents survive a bus reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[ptr_q] <= bus.bus_in;
        end
    end

    assign bus.bus_out = bus_out_q;
    assign bus.bus_oe  = oe_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.wack    = wack_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mux_bus_memory.sv
// Directed self-checking bench for mux_bus_memory (8-bit default and 16-bit/1024/8 variant).
// Drives both DUTs through shared CLK/RST and checks registered outputs 1ns after each edge.
module tb_mux_bus_memory;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    mux_bus_if #(.DATA_W(8), .MAX_BURST(4)) b8 ();
    mux_bus_if #(.DATA_W(16), .MAX_BURST(8)) b16 ();

    mux_bus_memory #(.DATA_W(8), .DEPTH(256), .MAX_BURST(4)) u8 (
        .CLK(CLK), .RST(RST), .bus(b8)
    );
    mux_bus_memory #(.DATA_W(16), .DEPTH(1024), .MAX_BURST(8)) u16 (
        .CLK(CLK), .RST(RST), .bus(b16)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request on the 8-bit bus for one edge, then drop it.
    task automatic req8(input logic rw, input logic [1:0] blen,
                        input logic [7:0] addr);
        b8.req = 1'b1; b8.rw = rw; b8.blen = blen; b8.bus_in = addr;
        tick();
        b8.req = 1'b0;
    endtask

    // Gapless 4-beat write, data = base+i.
    task automatic wr4(input logic [7:0] addr, input logic [7:0] base);
        req8(1'b0, 2'd3, addr);
        for (int i = 0; i < 4; i++) begin
            b8.wvalid = 1'b1; b8.bus_in = base + 8'(i);
            tick();
        end
        b8.wvalid = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0]  rexp [4];
        logic [15:0] d16;
        logic        wv_pat [6];
        int          k;

        b8.req = 0; b8.rw = 0; b8.blen = 0; b8.bus_in = 0; b8.wvalid = 0;
        b16.req = 0; b16.rw = 0; b16.blen = 0; b16.bus_in = 0; b16.wvalid = 0;

        // Reset state
        RST = 1'b1;
        tick(); tick();
        chk("rst_busy", b8.busy, 1'b0);
        chk("rst_rvalid", b8.rvalid, 1'b0);
        chk("rst_oe", b8.bus_oe, 1'b0);
        chk("rst_wack", b8.wack, 1'b0);
        chk("rst_err", b8.err, 1'b0);
        chk("rst_bus_out", b8.bus_out, 8'h00);
        RST = 1'b0;
        tick();

        // Preload 00..03 and 10..13
        wr4(8'h00, 8'h10);
        wr4(8'h10, 8'h70);

        // Burst read 0..3
        req8(1'b1, 2'd3, 8'h00);
        chk("rd_busy_k", b8.busy, 1'b1);
        chk("rd_oe_k", b8.bus_oe, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rd_rvalid%0d", i), b8.rvalid, 1'b1);
            chk($sformatf("rd_oe%0d", i), b8.bus_oe, 1'b1);
            chk($sformatf("rd_data%0d", i), b8.bus_out, 8'h10 + 8'(i));
        end
        chk("rd_busy_end", b8.busy, 1'b0);
        tick();
        chk("rd_rvalid_off", b8.rvalid, 1'b0);
        chk("rd_oe_off", b8.bus_oe, 1'b0);

        // Wrapping write FE..01 with wvalid gaps
        wv_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        req8(1'b0, 2'd3, 8'hFE);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            b8.wvalid = wv_pat[i];
            b8.bus_in = wv_pat[i] ? 8'hAA + 8'(k) : 8'h5A;
            tick();
            if (wv_pat[i]) k++;
            chk($sformatf("wr_wack%0d", i), b8.wack, wv_pat[i]);
        end
        b8.wvalid = 1'b0;
        chk("wr_busy_end", b8.busy, 1'b0);
        tick();
        chk("wr_wack_off", b8.wack, 1'b0);

        // Read back wrapped write
        rexp = '{8'hAA, 8'hAB, 8'hAC, 8'hAD};
        req8(1'b1, 2'd3, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("wrap_rd%0d", i), b8.bus_out, rexp[i]);
        end
        tick();

        // Single-beat read of 03
        req8(1'b1, 2'd0, 8'h03);
        chk("one_busy", b8.busy, 1'b1);
        tick();
        chk("one_rvalid", b8.rvalid, 1'b1);
        chk("one_data", b8.bus_out, 8'h13);
        chk("one_busy_end", b8.busy, 1'b0);
        tick();
        chk("one_rvalid_off", b8.rvalid, 1'b0);

        // Protocol error mid-burst and on last beat
        req8(1'b1, 2'd3, 8'hFE);
        b8.req = 1'b1; b8.rw = 1'b0; b8.bus_in = 8'h55;
        tick();
        b8.req = 1'b0;
        chk("perr_err1", b8.err, 1'b1);
        chk("perr_d0", b8.bus_out, 8'hAA);
        tick();
        chk("perr_err1_off", b8.err, 1'b0);
        chk("perr_d1", b8.bus_out, 8'hAB);
        tick();
        chk("perr_d2", b8.bus_out, 8'hAC);
        b8.req = 1'b1; b8.rw = 1'b0; b8.bus_in = 8'h55;
        tick();
        b8.req = 1'b0;
        chk("perr_err2", b8.err, 1'b1);
        chk("perr_d3", b8.bus_out, 8'hAD);
        chk("perr_busy_last", b8.busy, 1'b0);
        tick();
        chk("perr_err2_off", b8.err, 1'b0);
        chk("perr_no_new", b8.busy, 1'b0);
        chk("perr_rvalid_off", b8.rvalid, 1'b0);
        tick();

        // Reset mid write burst to 10
        req8(1'b0, 2'd3, 8'h10);
        b8.wvalid = 1'b1; b8.bus_in = 8'h60;
        tick();
        b8.bus_in = 8'h61;
        tick();
        chk("mrst_wack", b8.wack, 1'b1);
        RST = 1'b1;
        b8.req = 1'b1; b8.rw = 1'b1; b8.bus_in = 8'h62;
        tick();
        RST = 1'b0;
        b8.req = 1'b0; b8.wvalid = 1'b0;
        chk("mrst_busy", b8.busy, 1'b0);
        chk("mrst_wack0", b8.wack, 1'b0);
        chk("mrst_rvalid", b8.rvalid, 1'b0);
        chk("mrst_oe", b8.bus_oe, 1'b0);
        chk("mrst_err", b8.err, 1'b0);
        chk("mrst_bus_out", b8.bus_out, 8'h00);
        tick();
        chk("mrst_idle", b8.busy, 1'b0);
        rexp = '{8'h60, 8'h61, 8'h72, 8'h73};
        req8(1'b1, 2'd3, 8'h10);
        chk("mrst_accept", b8.busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mrst_rd%0d", i), b8.bus_out, rexp[i]);
        end
        tick();

        // 16-bit / 1024-deep / 8-beat wrap across 3FC..003
        b16.req = 1'b1; b16.rw = 1'b0; b16.blen = 3'd7;
        b16.bus_in = 16'hFBFC;
        tick();
        b16.req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b16.wvalid = 1'b1; b16.bus_in = 16'hA000 + 16'(i);
            tick();
            chk($sformatf("p16_wack%0d", i), b16.wack, 1'b1);
        end
        b16.wvalid = 1'b0;
        chk("p16_wr_done", b16.busy, 1'b0);
        tick();
        b16.req = 1'b1; b16.rw = 1'b1; b16.blen = 3'd7;
        b16.bus_in = 16'h03FC;
        tick();
        b16.req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            d16 = 16'hA000 + 16'(i);
            chk($sformatf("p16_rv%0d", i), b16.rvalid, 1'b1);
            chk($sformatf("p16_rd%0d", i), b16.bus_out, d16);
        end
        chk("p16_busy_end", b16.busy, 1'b0);
        tick();
        chk("p16_rvalid_off", b16.rvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
